shiftreg_sipo_rx: RTL and testbench

SHIFTREG_SIPO_RX -- requirements
Module: shiftreg_sipo_rx

---
 rtl/shiftreg_sipo_rx_pkg.sv | 15 +
 rtl/shiftreg_sipo_rx_counter.sv | 32 +++
 rtl/shiftreg_sipo_rx.sv | 97 +++++++++
 tb/tb_shiftreg_sipo_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_sipo_rx_pkg.sv
// Shared definitions for the serial-in parallel-out receiver.
// FSM encoding, default word size and counter sizing helper.
package shiftreg_sipo_rx_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shiftreg_sipo_rx_counter.sv
// Bit counter for one frame.
// tc flags that the next enabled bit is the last.
module rx_bit_counter
  import shiftreg_sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  input  logic restart,
  output logic tc
);

  logic [CW-1:0] count;

  assign tc = (count == CW'(WIDTH - 1));

  // restart loads 1; otherwise count while a frame is open, wrap at WIDTH
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (restart)
        count <= CW'(1);
      else if (count != '0)
        count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/shiftreg_sipo_rx.sv
// Serial-in parallel-out receiver with valid/ack hold
// and sticky overrun when a finished word has no room.
module shiftreg_sipo_rx
  import shiftreg_sipo_rx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic             sdata,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] seed;
  logic             tc;
  logic             start;
  logic             done;

  assign start = enable & load;
  assign done  = (state == SHIFT) & enable & ~load & tc;
  assign busy  = (state == SHIFT);

  // Next shift-register value and first-bit seed for the chosen bit order
  always_comb begin
    word = '0;
    seed = '0;
    if (MSB_FIRST) begin
      word = {sr[WIDTH-2:0], sdata};
      seed = {{(WIDTH-1){1'b0}}, sdata};
    end else begin
      word = {sdata, sr[WIDTH-1:1]};
      seed = {sdata, {(WIDTH-1){1'b0}}};
    end
  end

  rx_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk     (clk),
    .clear   (clear),
    .enable  (enable),
    .restart (load),
    .tc      (tc)
  );

  // Frame FSM: load starts or restarts, last bit returns to idle
  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      state <= IDLE;
    else if (start)
      state <= SHIFT;
    else if (done)
      state <= IDLE;
  end

  // Shift register captures each enabled bit inside a frame
  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      sr <= '0;
    else if (start)
      sr <= seed;
    else if (enable && state == SHIFT)
      sr <= word;
  end

  // Output word, valid hold and sticky overrun
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (done) begin
      if (!valid || ack) begin
        q     <= word;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (ack && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shiftreg_sipo_rx.sv
// Directed bench for shiftreg_sipo_rx with a frame-level
// reference model compared every cycle plus literal checks.
module tb_shiftreg_sipo_rx;

  localparam int W  = 4;
  localparam bit MF = 1'b1;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic         sdata = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] q;
  logic         valid;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit           m_active;
  int           frame[$];
  logic [W-1:0] m_q;
  bit           m_valid;
  bit           m_ovr;

  always #5 clk = ~clk;

  shiftreg_sipo_rx #(
    .WIDTH     (W),
    .MSB_FIRST (MF)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .enable  (enable),
    .load    (load),
    .sdata   (sdata),
    .ack     (ack),
    .q       (q),
    .valid   (valid),
    .overrun (overrun),
    .busy    (busy)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    frame.delete();
    m_q = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
  endfunction

  // One rising edge of the frame-level model
  task automatic model_edge(input bit en, input bit ld,
                            input bit sd, input bit ak);
    logic [W-1:0] w;
    bit fin;
    fin = 1'b0;
    w = '0;
    if (en && ld) begin
      frame.delete();
      frame.push_back(int'(sd));
      m_active = 1'b1;
    end else if (en && m_active) begin
      frame.push_back(int'(sd));
      if (frame.size() == W) begin
        for (int i = 0; i < W; i++)
          if (MF) w[W-1-i] = frame[i][0];
          else    w[i]     = frame[i][0];
        fin = 1'b1;
        m_active = 1'b0;
        frame.delete();
      end
    end
    if (fin) begin
      if (!m_valid || ak) begin
        m_q = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (ak && m_valid) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit en, input bit ld,
                      input bit sd, input bit ak);
    enable = en;
    load = ld;
    sdata = sd;
    ack = ak;
    @(posedge clk);
    if (!clear) model_edge(en, ld, sd, ak);
    @(negedge clk);
  endtask

  task automatic lit(input string n, input logic [W-1:0] eq,
                     input bit ev, input bit eo, input bit eb);
    chk({n, "_q"}, 32'(q), 32'(eq));
    chk({n, "_valid"}, 32'(valid), 32'(ev));
    chk({n, "_ovr"}, 32'(overrun), 32'(eo));
    chk({n, "_busy"}, 32'(busy), 32'(eb));
  endtask

  // Pulse clear mid-cycle and hold it with junk inputs
  task automatic do_clear();
    #1 clear = 1'b1;
    model_reset();
    #1 lit("clear_now", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1, 1);
    step(1, 0, 1, 0);
    step(1, 1, 0, 1);
    lit("clear_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    #1 clear = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_q", 32'(q), 32'(m_q));
    chk("cyc_valid", 32'(valid), 32'(m_valid));
    chk("cyc_ovr", 32'(overrun), 32'(m_ovr));
    chk("cyc_busy", 32'(busy), 32'(m_active));
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    lit("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    #1 clear = 1'b0;

    // basic frame 1011
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    lit("f1_b3", 4'b0000, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 0);
    lit("f1_done", 4'b1011, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    lit("f1_ack", 4'b1011, 1'b0, 1'b0, 1'b0);

    // enable gap of 3 cycles between bits 2 and 3
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    lit("gap_hold", 4'b1011, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 0);
    lit("gap_b3", 4'b1011, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 0);
    lit("gap_done", 4'b1011, 1'b1, 1'b0, 1'b0);

    // overrun: frame 0110 while 1011 still unacked
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    lit("ovr", 4'b1011, 1'b1, 1'b1, 1'b0);
    step(0, 0, 0, 0);
    lit("ovr_sticky", 4'b1011, 1'b1, 1'b1, 1'b0);

    do_clear();

    // ack on the last-bit edge replaces the word
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    lit("ack_last", 4'b0110, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    lit("ack_idle", 4'b0110, 1'b0, 1'b0, 1'b0);

    // restart after two bits
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    lit("rst_mid", 4'b0110, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    lit("rst_done", 4'b0110, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);

    // restart on the last-bit cycle, then frame 0011
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    lit("rst_last", 4'b0110, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    lit("f0011", 4'b0011, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);

    // clear after two bits, then a clean frame
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    do_clear();
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    lit("post_clr", 4'b1011, 1'b1, 1'b0, 1'b0);

    // pseudo-random traffic against the model
    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 5) == 0),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
